// File: rtl/prog_mem_boot_if.sv
// Fetch port and byte-stream loader bus of the Jac1-8 program memory.
// The memory is the slave; the CPU/loader side is the master.
interface prog_mem_boot_if #(
    parameter int PC_WIDTH = 8,
    parameter int IR_WIDTH = 16
);
    logic [PC_WIDTH-1:0] pc;
    logic [IR_WIDTH-1:0] ir;
    logic                ld_start;
    logic                ld_valid;
    logic [7:0]          ld_data;
    logic                ld_ready;
    logic                cpu_hold;
    logic                ld_done;
    logic                ld_err;

    modport master (
        output pc, ld_start, ld_valid, ld_data,
        input  ir, ld_ready, cpu_hold, ld_done, ld_err
    );

    modport slave (
        input  pc, ld_start, ld_valid, ld_data,
        output ir, ld_ready, cpu_hold, ld_done, ld_err
    );
endinterface

// File: rtl/prog_mem_boot.sv
// Jac1-8 program memory with a registered fetch port and a framed byte-stream
// loader (count, MSB-first words, checksum) that zero-fills the unused tail.
module prog_mem_boot #(
    parameter int PC_WIDTH = 8,
    parameter int IR_WIDTH = 16,
    parameter int CMD_CNT  = 256
) (
    input  logic           clk,
    input  logic           res_n,
    prog_mem_boot_if.slave bus
);
    localparam int BPW = IR_WIDTH / 8;
    localparam int AW  = (CMD_CNT > 1) ? $clog2(CMD_CNT) : 1;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [8:0]     CNT_MAX   = 9'(CMD_CNT);
    localparam logic [8:0]     LAST_ADDR = 9'(CMD_CNT - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CSUM,
        CLEAR,
        FINISH
    } state_t;

    state_t state, next_state;

    logic [IR_WIDTH-1:0] mem [CMD_CNT];
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] word_next;
    logic [IR_WIDTH-1:0] mem_wdata;
    logic [7:0]          sum;
    logic [7:0]          sum_next;
    logic [8:0]          word_cnt;
    logic [8:0]          waddr;
    logic [BCW-1:0]      byte_cnt;
    logic                err_q;
    logic                ready;
    logic                hold;
    logic                done;
    logic                accept;
    logic                last_byte;
    logic                count_bad;
    logic                mem_we;
    logic                pc_in_range;

    assign accept      = bus.ld_valid && ready;
    assign last_byte   = (byte_cnt == LAST_BYTE);
    assign sum_next    = sum + bus.ld_data;
    assign count_bad   = (bus.ld_data == 8'd0) || ({1'b0, bus.ld_data} > CNT_MAX);
    assign pc_in_range = ({1'b0, bus.pc} < (PC_WIDTH + 1)'(CMD_CNT));

    // Bytes of a word arrive MSB-first; the partial word holds the bytes seen so far.
    generate
        if (BPW > 1) begin : g_multi
            logic [IR_WIDTH-9:0] partial;

            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    partial <= '0;
                end else if (state == DATA && accept) begin
                    partial <= word_next[IR_WIDTH-9:0];
                end
            end

            assign word_next = {partial, bus.ld_data};
        end else begin : g_single
            assign word_next = bus.ld_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        hold       = 1'b1;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                hold = 1'b0;
                if (bus.ld_start) begin
                    next_state = COUNT;
                end
            end
            COUNT: begin
                ready = 1'b1;
                if (bus.ld_valid) begin
                    next_state = count_bad ? FINISH : DATA;
                end
            end
            DATA: begin
                ready = 1'b1;
                if (bus.ld_valid && last_byte) begin
                    mem_we    = 1'b1;
                    mem_wdata = word_next;
                    if (waddr == word_cnt - 9'd1) begin
                        next_state = CSUM;
                    end
                end
            end
            CSUM: begin
                ready = 1'b1;
                if (bus.ld_valid) begin
                    next_state = (word_cnt < CNT_MAX) ? CLEAR : FINISH;
                end
            end
            CLEAR: begin
                mem_we = 1'b1;
                if (waddr == LAST_ADDR) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Loader bookkeeping; an accepted start wipes the previous load's error and counters.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sum      <= '0;
            word_cnt <= '0;
            waddr    <= '0;
            byte_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.ld_start) begin
                sum      <= '0;
                word_cnt <= '0;
                waddr    <= '0;
                byte_cnt <= '0;
                err_q    <= 1'b0;
            end
        end else begin
            if (accept) begin
                sum <= sum_next;
            end
            case (state)
                COUNT: begin
                    if (accept) begin
                        word_cnt <= {1'b0, bus.ld_data};
                        if (count_bad) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (last_byte) begin
                            byte_cnt <= '0;
                            waddr    <= waddr + 9'd1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                CSUM: begin
                    if (accept && sum_next != 8'd0) begin
                        err_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    waddr <= waddr + 9'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Memory contents survive reset on purpose: an aborted load keeps what it wrote.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr[AW-1:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ir_q <= '0;
        end else if (hold || !pc_in_range) begin
            ir_q <= '0;
        end else begin
            ir_q <= mem[bus.pc[AW-1:0]];
        end
    end

    assign bus.ir       = ir_q;
    assign bus.ld_ready = ready;
    assign bus.cpu_hold = hold;
    assign bus.ld_done  = done;
    assign bus.ld_err   = err_q;
endmodule

// File: tb/tb_prog_mem_boot.sv
// Self-checking bench for prog_mem_boot: loads streams, then reads the whole
// memory back through the fetch port against a scoreboard of expected words.
module tb_prog_mem_boot;
    localparam int PCW = 8;
    localparam int IRW = 16;

    logic clk   = 1'b0;
    logic res_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   hold_en     = 1'b0;
    bit   prev_hold   = 1'b0;

    logic [15:0] model [256];
    logic [15:0] exp_q [$];
    logic [7:0]  stream [$];
    logic [7:0]  good_bytes [8];
    logic [7:0]  s64 [4];

    always #5 clk = ~clk;

    prog_mem_boot_if #(.PC_WIDTH(PCW), .IR_WIDTH(IRW)) bus ();
    prog_mem_boot_if #(.PC_WIDTH(PCW), .IR_WIDTH(IRW)) bus64 ();

    prog_mem_boot #(.PC_WIDTH(PCW), .IR_WIDTH(IRW), .CMD_CNT(256)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    prog_mem_boot #(.PC_WIDTH(PCW), .IR_WIDTH(IRW), .CMD_CNT(64)) dut64 (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus64)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (hold_en) bus.pc = 8'($urandom);
    endtask

    // While the CPU is held, whatever pc it presents must fetch a NOP.
    always @(negedge clk) begin
        if (hold_en && prev_hold) checkOutput("hold_ir", 32'(bus.ir), 32'd0);
        prev_hold = bus.cpu_hold;
    end

    task automatic loadGood();
        stream.delete();
        foreach (good_bytes[i]) stream.push_back(good_bytes[i]);
    endtask

    task automatic applyStimulus(input bit gaps, input int nbytes);
        @(negedge clk);
        bus.ld_start = 1'b1;
        cyc = 1;
        tick();
        bus.ld_start = 1'b0;
        checkOutput("hold_on_start", 32'(bus.cpu_hold), 32'd1);
        checkOutput("err_cleared", 32'(bus.ld_err), 32'd0);
        for (int i = 0; i < nbytes; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.ld_valid = 1'b0;
                    bus.ld_data  = 8'($urandom);
                    bus.ld_start = 1'($urandom_range(0, 1));
                    tick();
                end
                bus.ld_start = 1'b0;
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = stream[i];
            checkOutput("ld_ready", 32'(bus.ld_ready), 32'd1);
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
    endtask

    task automatic waitDone(input bit pulse_start);
        int guard = 0;
        while (bus.ld_done !== 1'b1 && guard < 600) begin
            bus.ld_start = pulse_start ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            guard++;
        end
        bus.ld_start = 1'b0;
        checkOutput("ld_done_seen", 32'(bus.ld_done), 32'd1);
    endtask

    task automatic releaseCheck(input string tag);
        tick();
        checkOutput({tag, "_done_pulse"}, 32'(bus.ld_done), 32'd0);
        checkOutput({tag, "_hold_released"}, 32'(bus.cpu_hold), 32'd0);
    endtask

    task automatic dumpMem(input string tag);
        exp_q.delete();
        for (int i = 0; i <= 256; i++) begin
            tick();
            if (exp_q.size() > 0) checkOutput(tag, 32'(bus.ir), 32'(exp_q.pop_front()));
            if (i < 256) begin
                bus.pc = 8'(i);
                exp_q.push_back(model[i]);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        bus.pc = '0;   bus.ld_start = 1'b0;   bus.ld_valid = 1'b0;   bus.ld_data = '0;
        bus64.pc = '0; bus64.ld_start = 1'b0; bus64.ld_valid = 1'b0; bus64.ld_data = '0;
        foreach (model[i]) model[i] = 16'h0000;
        good_bytes = '{8'h03, 8'h49, 8'h03, 8'h4A, 8'h14, 8'h09, 8'h10, 8'h3A};
        s64        = '{8'h01, 8'hBE, 8'hEF, 8'h52};

        #2;
        checkOutput("rst_ir", 32'(bus.ir), 32'd0);
        checkOutput("rst_ready", 32'(bus.ld_ready), 32'd0);
        checkOutput("rst_hold", 32'(bus.cpu_hold), 32'd0);
        checkOutput("rst_done", 32'(bus.ld_done), 32'd0);
        checkOutput("rst_err", 32'(bus.ld_err), 32'd0);
        #10 res_n = 1'b1;

        // Small memory: a one-word load, out-of-range fetch, then an oversize count.
        @(negedge clk); bus64.ld_start = 1'b1;
        @(negedge clk); bus64.ld_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus64.ld_valid = 1'b1;
            bus64.ld_data  = s64[i];
            @(negedge clk);
        end
        bus64.ld_valid = 1'b0;
        checkOutput("c64_good_err", 32'(bus64.ld_err), 32'd0);
        for (int g = 0; g < 100 && bus64.ld_done !== 1'b1; g++) @(negedge clk);
        checkOutput("c64_good_done", 32'(bus64.ld_done), 32'd1);
        @(negedge clk); bus64.pc = 8'd0;
        @(negedge clk); checkOutput("c64_word0", 32'(bus64.ir), 32'h0000BEEF); bus64.pc = 8'd64;
        @(negedge clk); checkOutput("c64_pc_oob", 32'(bus64.ir), 32'd0);
        bus64.ld_start = 1'b1;
        @(negedge clk); bus64.ld_start = 1'b0; bus64.ld_valid = 1'b1; bus64.ld_data = 8'h41;
        @(negedge clk); bus64.ld_valid = 1'b0;
        checkOutput("c64_count_err", 32'(bus64.ld_err), 32'd1);
        checkOutput("c64_count_done", 32'(bus64.ld_done), 32'd1);
        @(negedge clk);
        checkOutput("c64_done_pulse", 32'(bus64.ld_done), 32'd0);
        checkOutput("c64_hold_released", 32'(bus64.cpu_hold), 32'd0);
        bus64.pc = 8'd0;
        @(negedge clk); checkOutput("c64_mem_kept", 32'(bus64.ir), 32'h0000BEEF);

        // Good load with back-to-back bytes.
        loadGood();
        applyStimulus(1'b0, 8);
        checkOutput("good_err", 32'(bus.ld_err), 32'd0);
        waitDone(1'b0);
        checkOutput("good_done_cycle", 32'(cyc), 32'd263);
        releaseCheck("good");
        model[0] = 16'h4903; model[1] = 16'h4A14; model[2] = 16'h0910;
        dumpMem("good_mem");

        // Bad checksum: words still land, tail still cleared.
        stream.delete();
        foreach (good_bytes[i]) stream.push_back(8'h00);
        stream[0] = 8'h03; stream[1] = 8'h12; stream[2] = 8'h34; stream[3] = 8'h56;
        stream[4] = 8'h78; stream[5] = 8'h9A; stream[6] = 8'hBC; stream[7] = 8'h94;
        applyStimulus(1'b0, 8);
        checkOutput("csum_err_set", 32'(bus.ld_err), 32'd1);
        waitDone(1'b0);
        checkOutput("csum_done_cycle", 32'(cyc), 32'd263);
        releaseCheck("csum");
        checkOutput("csum_err_sticky", 32'(bus.ld_err), 32'd1);
        model[0] = 16'h1234; model[1] = 16'h5678; model[2] = 16'h9ABC;
        dumpMem("csum_mem");

        // Zero count: immediate finish, no writes.
        stream.delete();
        stream.push_back(8'h00);
        applyStimulus(1'b0, 1);
        checkOutput("zero_count_err", 32'(bus.ld_err), 32'd1);
        checkOutput("zero_count_done", 32'(bus.ld_done), 32'd1);
        releaseCheck("zero_count");
        dumpMem("zero_count_mem");

        // Backpressure gaps plus stray start pulses during the load.
        loadGood();
        hold_en = 1'b1;
        applyStimulus(1'b1, 8);
        waitDone(1'b1);
        hold_en = 1'b0;
        checkOutput("gap_err", 32'(bus.ld_err), 32'd0);
        releaseCheck("gap");
        model[0] = 16'h4903; model[1] = 16'h4A14; model[2] = 16'h0910;
        dumpMem("gap_mem");

        // Reset after two of three words.
        stream.delete();
        foreach (good_bytes[i]) stream.push_back(8'h00);
        stream[0] = 8'h03; stream[1] = 8'h11; stream[2] = 8'h22; stream[3] = 8'h33;
        stream[4] = 8'h44; stream[5] = 8'h55; stream[6] = 8'h66; stream[7] = 8'h98;
        applyStimulus(1'b0, 5);
        #2 res_n = 1'b0;
        #1;
        checkOutput("abort_ir", 32'(bus.ir), 32'd0);
        checkOutput("abort_ready", 32'(bus.ld_ready), 32'd0);
        checkOutput("abort_hold", 32'(bus.cpu_hold), 32'd0);
        checkOutput("abort_done", 32'(bus.ld_done), 32'd0);
        checkOutput("abort_err", 32'(bus.ld_err), 32'd0);
        @(negedge clk); res_n = 1'b1;
        tick();
        checkOutput("abort_idle", 32'(bus.cpu_hold), 32'd0);
        model[0] = 16'h1122; model[1] = 16'h3344;
        dumpMem("abort_mem");

        // Two-word load after the abort; clears the stale third word.
        stream.delete();
        stream.push_back(8'h02); stream.push_back(8'hAB); stream.push_back(8'hCD);
        stream.push_back(8'h12); stream.push_back(8'h34); stream.push_back(8'h40);
        applyStimulus(1'b0, 6);
        checkOutput("reload_err", 32'(bus.ld_err), 32'd0);
        waitDone(1'b0);
        checkOutput("reload_done_cycle", 32'(cyc), 32'd262);
        releaseCheck("reload");
        model[0] = 16'hABCD; model[1] = 16'h1234; model[2] = 16'h0000;
        dumpMem("reload_mem");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
